// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the serial framebuffer loader.
//   - escape/command byte codes
//   - loader FSM state encoding
//   - default LCD geometry (240 columns x 8 bytes)
//   - fb_rev8: byte bit-reversal helper
package fb_pkg;

  localparam logic [7:0] FB_ESC       = 8'h1B;
  localparam logic [7:0] FB_CMD_LIT   = 8'h00;
  localparam logic [7:0] FB_CMD_SYNC  = 8'h53;
  localparam logic [7:0] FB_CMD_CLEAR = 8'h43;
  localparam logic [7:0] FB_CMD_GOTO  = 8'h50;

  localparam int unsigned FB_COLS_DEF  = 240;
  localparam int unsigned FB_ROWS_DEF  = 8;
  localparam int unsigned FB_COL_W_DEF = 8;
  localparam int unsigned FB_ROW_W_DEF = 3;

  typedef enum logic [2:0] {
    FB_ST_IDLE   = 3'd0,
    FB_ST_ESC    = 3'd1,
    FB_ST_GOTO_X = 3'd2,
    FB_ST_GOTO_Y = 3'd3,
    FB_ST_CLEAR  = 3'd4
  } fb_state_e;

  // bit0 <-> bit7 swap; the LCD shifts bytes in LSB-first
  function automatic logic [7:0] fb_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_cursor.sv
// fb_cursor: column-major (row-fastest) cursor for the framebuffer.
// Ports:
//   clk, reset          clock, async active-high reset
//   i_zero              force cursor to (0,0)           (highest priority)
//   i_load, i_load_col,
//   i_load_row          load an absolute position
//   i_adv               advance one position, wrapping at (COLS-1,ROWS-1)
//   o_col, o_row        current cursor
//   o_wrap_c            combinational: cursor sits on the last position
module fb_cursor #(
  parameter int unsigned COLS  = fb_pkg::FB_COLS_DEF,
  parameter int unsigned ROWS  = fb_pkg::FB_ROWS_DEF,
  parameter int unsigned COL_W = fb_pkg::FB_COL_W_DEF,
  parameter int unsigned ROW_W = fb_pkg::FB_ROW_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_zero,
  input  logic             i_load,
  input  logic [COL_W-1:0] i_load_col,
  input  logic [ROW_W-1:0] i_load_row,
  input  logic             i_adv,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_wrap_c
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_row_last;
  logic             w_col_last;

  assign w_row_last = (r_row == ROW_W'(ROWS - 1));
  assign w_col_last = (r_col == COL_W'(COLS - 1));
  assign o_wrap_c   = w_row_last && w_col_last;
  assign o_col      = r_col;
  assign o_row      = r_row;

  // zero > load > advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_zero) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_col <= i_load_col;
      r_row <= i_load_row;
    end else if (i_adv) begin
      if (w_row_last) begin
        r_row <= '0;
        r_col <= w_col_last ? '0 : r_col + COL_W'(1);
      end else begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_serial_loader.sv
// fb_serial_loader: UART byte stream to column-major framebuffer write port,
// with an escape-coded command layer (literal ESC, frame sync, clear, goto).
// Ports:
//   clk, reset             clock, async active-high reset
//   rx_data, rx_strobe     received byte and its one-cycle valid pulse
//   wr_en/wr_col/wr_row/
//   wr_data                registered RAM write port
//   busy                   clear sweep in progress (strobes are dropped)
//   frame_done             pulse on the write that wraps the cursor to (0,0)
//   proto_err              pulse on unknown command or out-of-range goto
//   overrun                pulse when a byte arrives during a clear sweep
// Optional (macro FB_LOADER_STATS_EN):
//   frame_count[15:0]      wrapping count of frame_done pulses
//   err_count[7:0]         saturating count of proto_err/overrun pulses
module fb_serial_loader #(
  parameter int unsigned COLS        = fb_pkg::FB_COLS_DEF,
  parameter int unsigned ROWS        = fb_pkg::FB_ROWS_DEF,
  parameter int unsigned COL_W       = fb_pkg::FB_COL_W_DEF,
  parameter int unsigned ROW_W       = fb_pkg::FB_ROW_W_DEF,
  parameter int unsigned BIT_REVERSE = 1,
  parameter logic [7:0]  CLEAR_VAL   = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_strobe,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic             proto_err,
  output logic             overrun
`ifdef FB_LOADER_STATS_EN
  ,
  output logic [15:0]      frame_count,
  output logic [7:0]       err_count
`endif
);

  import fb_pkg::*;

  fb_state_e        r_state, w_next_state;
  logic [7:0]       r_x;
  logic             r_wr_en, r_busy, r_frame_done, r_proto_err, r_overrun;
  logic [COL_W-1:0] r_wr_col;
  logic [ROW_W-1:0] r_wr_row;
  logic [7:0]       r_wr_data;

  logic [COL_W-1:0] w_cur_col;
  logic [ROW_W-1:0] w_cur_row;
  logic             w_cur_wrap;
  logic             w_wr_en, w_frame_done, w_proto_err, w_overrun;
  logic [7:0]       w_wr_data;
  logic             w_cur_zero, w_cur_load, w_cur_adv, w_x_latch;
  logic [7:0]       w_pay, w_pay_fmt;
  logic             w_x_ok, w_y_ok;

  fb_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_cursor (
    .clk        (clk),
    .reset      (reset),
    .i_zero     (w_cur_zero),
    .i_load     (w_cur_load),
    .i_load_col (r_x[COL_W-1:0]),
    .i_load_row (rx_data[ROW_W-1:0]),
    .i_adv      (w_cur_adv),
    .o_col      (w_cur_col),
    .o_row      (w_cur_row),
    .o_wrap_c   (w_cur_wrap)
  );

  // in ESC state the only payload is the escaped literal 0x1B
  assign w_pay     = (r_state == FB_ST_ESC) ? FB_ESC : rx_data;
  assign w_pay_fmt = (BIT_REVERSE != 0) ? fb_rev8(w_pay) : w_pay;

  // field-width range check: truncated upper bits must be clear
  assign w_x_ok = ((r_x >> COL_W) == 8'd0) && (32'(r_x[COL_W-1:0]) < COLS);
  assign w_y_ok = ((rx_data >> ROW_W) == 8'd0) && (32'(rx_data[ROW_W-1:0]) < ROWS);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FB_ST_IDLE;
    else       r_state <= w_next_state;
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FB_ST_IDLE:   if (rx_strobe && rx_data == FB_ESC) w_next_state = FB_ST_ESC;
      FB_ST_ESC:    if (rx_strobe) begin
                      case (rx_data)
                        FB_CMD_CLEAR: w_next_state = FB_ST_CLEAR;
                        FB_CMD_GOTO:  w_next_state = FB_ST_GOTO_X;
                        default:      w_next_state = FB_ST_IDLE;
                      endcase
                    end
      FB_ST_GOTO_X: if (rx_strobe) w_next_state = FB_ST_GOTO_Y;
      FB_ST_GOTO_Y: if (rx_strobe) w_next_state = FB_ST_IDLE;
      FB_ST_CLEAR:  if (w_cur_wrap) w_next_state = FB_ST_IDLE;
      default:      w_next_state = FB_ST_IDLE;
    endcase
  end

  // output / datapath control
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_data    = 8'h00;
    w_frame_done = 1'b0;
    w_proto_err  = 1'b0;
    w_overrun    = 1'b0;
    w_cur_zero   = 1'b0;
    w_cur_load   = 1'b0;
    w_cur_adv    = 1'b0;
    w_x_latch    = 1'b0;
    case (r_state)
      FB_ST_IDLE: if (rx_strobe && rx_data != FB_ESC) begin
        w_wr_en      = 1'b1;
        w_wr_data    = w_pay_fmt;
        w_cur_adv    = 1'b1;
        w_frame_done = w_cur_wrap;
      end
      FB_ST_ESC: if (rx_strobe) begin
        case (rx_data)
          FB_CMD_LIT: begin
            w_wr_en      = 1'b1;
            w_wr_data    = w_pay_fmt;
            w_cur_adv    = 1'b1;
            w_frame_done = w_cur_wrap;
          end
          FB_CMD_SYNC, FB_CMD_CLEAR: w_cur_zero = 1'b1;
          FB_CMD_GOTO: ;
          default: w_proto_err = 1'b1;
        endcase
      end
      FB_ST_GOTO_X: w_x_latch = rx_strobe;
      FB_ST_GOTO_Y: if (rx_strobe) begin
        if (w_x_ok && w_y_ok) w_cur_load  = 1'b1;
        else                  w_proto_err = 1'b1;
      end
      // sweep ends on the wrap, which also leaves the cursor at (0,0)
      FB_ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_data = CLEAR_VAL;
        w_cur_adv = 1'b1;
        w_overrun = rx_strobe;
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en      <= 1'b0;
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_wr_data    <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_x          <= 8'h00;
    end else begin
      r_wr_en      <= w_wr_en;
      if (w_wr_en) begin
        r_wr_col  <= w_cur_col;
        r_wr_row  <= w_cur_row;
        r_wr_data <= w_wr_data;
      end
      r_busy       <= (w_next_state == FB_ST_CLEAR);
      r_frame_done <= w_frame_done;
      r_proto_err  <= w_proto_err;
      r_overrun    <= w_overrun;
      if (w_x_latch) r_x <= rx_data;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_col     = r_wr_col;
  assign wr_row     = r_wr_row;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign proto_err  = r_proto_err;
  assign overrun    = r_overrun;

`ifdef FB_LOADER_STATS_EN
  logic [15:0] r_frame_count;
  logic [7:0]  r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= 16'h0000;
      r_err_count   <= 8'h00;
    end else begin
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if ((w_proto_err || w_overrun) && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;
`endif

endmodule

// File: tb/tb_fb_serial_loader.sv
// Self-checking bench for fb_serial_loader (COLS=4, ROWS=2).
// Reference model: linear cursor index plus a byte-stream interpreter.
module tb_fb_serial_loader;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 2;
  localparam int unsigned COL_W = 2;
  localparam int unsigned ROW_W = 1;
  localparam int unsigned NPOS  = COLS * ROWS;
  localparam logic [7:0]  CLR_V = 8'h00;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_strobe = 1'b0;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [7:0]       wr_data;
  logic             busy, frame_done, proto_err, overrun;
`ifdef FB_LOADER_STATS_EN
  logic [15:0]      frame_count;
  logic [7:0]       err_count;
`endif

  fb_serial_loader #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
    .BIT_REVERSE(1), .CLEAR_VAL(CLR_V)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .proto_err  (proto_err),
    .overrun    (overrun)
`ifdef FB_LOADER_STATS_EN
    ,
    .frame_count(frame_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state: linear position (col*ROWS+row), parser mode, latched x
  int         m_pos  = 0;
  int         m_mode = 0;  // 0 normal, 1 after ESC, 2 want x, 3 want y
  logic [7:0] m_x    = 8'h00;

  function automatic logic [7:0] rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  // {wr_en, col, row, data, busy, frame_done, proto_err, overrun}
  function automatic logic [15:0] observe();
    return {wr_en, wr_col, wr_row, wr_data, busy, frame_done, proto_err, overrun};
  endfunction

  task automatic model_step(input logic [7:0] b, output logic [15:0] exp, output logic clr);
    logic       do_wr;
    logic [7:0] wb;
    logic       wr, fd, pe;
    int         col, row;
    logic [7:0] d;
    do_wr = 1'b0; wb = 8'h00; wr = 1'b0; fd = 1'b0; pe = 1'b0;
    col = 0; row = 0; d = 8'h00; clr = 1'b0;
    case (m_mode)
      0: if (b == 8'h1B) m_mode = 1; else begin do_wr = 1'b1; wb = b; end
      1: begin
        m_mode = 0;
        if (b == 8'h00)      begin do_wr = 1'b1; wb = 8'h1B; end
        else if (b == 8'h53) m_pos = 0;
        else if (b == 8'h43) begin clr = 1'b1; m_pos = 0; end
        else if (b == 8'h50) m_mode = 2;
        else                 pe = 1'b1;
      end
      2: begin m_x = b; m_mode = 3; end
      default: begin
        m_mode = 0;
        if (int'(m_x) < COLS && int'(b) < ROWS) m_pos = int'(m_x) * ROWS + int'(b);
        else pe = 1'b1;
      end
    endcase
    if (do_wr) begin
      wr  = 1'b1;
      col = m_pos / ROWS;
      row = m_pos % ROWS;
      d   = rev(wb);
      fd  = (m_pos == NPOS - 1);
      m_pos = (m_pos + 1) % NPOS;
    end
    exp = {wr, COL_W'(col), ROW_W'(row), d, clr, fd, pe, 1'b0};
  endtask

  // one strobed byte; returns observed (address/data masked when no write) and expected
  task automatic drive_byte(input logic [7:0] b, output logic [15:0] obs,
                            output logic [15:0] exp, output logic clr);
    rx_data   = b;
    rx_strobe = 1'b1;
    model_step(b, exp, clr);
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    rx_data   = 8'($urandom);
    obs = observe();
    if (!exp[15]) obs[14:4] = '0;
  endtask

  // one clear-sweep cycle k, optionally with a stray strobe
  task automatic sweep_cycle(input int k, input logic inject,
                             output logic [15:0] obs, output logic [15:0] exp);
    if (inject) begin
      rx_strobe = 1'b1;
      rx_data   = 8'($urandom);
    end
    exp = {1'b1, COL_W'(k / ROWS), ROW_W'(k % ROWS), CLR_V,
           (k < NPOS - 1), 1'b0, 1'b0, inject};
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    obs = observe();
  endtask

  task automatic idle_cycle(output logic [15:0] obs, output logic [15:0] exp);
    exp = 16'h0000;
    @(posedge clk); #1;
    obs = observe();
    obs[14:4] = '0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1'b1; rx_strobe = 1'b0;
    #1;
    obs = observe();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_async: got %h expected 0000", obs); end
    repeat (2) @(posedge clk);
    #1;
    obs = observe();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_held: got %h expected 0000", obs); end
    @(negedge clk);
    reset = 1'b0;
    m_pos = 0; m_mode = 0;
  endtask

  task automatic test_payload_frame();
    logic [15:0] obs, exp;
    logic        clr;
    for (int i = 1; i <= 8; i++) begin
      drive_byte(8'(i), obs, exp, clr);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL payload_%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_literal_sync();
    logic [15:0] obs, exp;
    logic        clr;
    logic [7:0]  seq [5];
    seq = '{8'h1B, 8'h00, 8'h1B, 8'h53, 8'h3C};
    for (int i = 0; i < 5; i++) begin
      drive_byte(seq[i], obs, exp, clr);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL literal_sync_%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_goto();
    logic [15:0] obs, exp;
    logic        clr;
    logic [7:0]  seq [10];
    seq = '{8'h1B, 8'h50, 8'h02, 8'h01, 8'hAA, 8'h1B, 8'h50, 8'h04, 8'h00, 8'h5A};
    for (int i = 0; i < 10; i++) begin
      drive_byte(seq[i], obs, exp, clr);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL goto_%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_clear_overrun();
    logic [15:0] obs, exp;
    logic        clr;
    drive_byte(8'h1B, obs, exp, clr);
    drive_byte(8'h43, obs, exp, clr);
    checks++;
    if (obs !== exp || !clr) begin errors++; $display("FAIL clear_start: got %h expected %h", obs, exp); end
    for (int k = 0; k < int'(NPOS); k++) begin
      sweep_cycle(k, (k == 2), obs, exp);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL clear_sweep_%0d: got %h expected %h", k, obs, exp); end
    end
    // strobe in the cycle busy falls is accepted
    drive_byte(8'h21, obs, exp, clr);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_after: got %h expected %h", obs, exp); end
    idle_cycle(obs, exp);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_idle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_bad_cmd();
    logic [15:0] obs, exp;
    logic        clr;
    logic [7:0]  seq [3];
    seq = '{8'h1B, 8'h7F, 8'h11};
    for (int i = 0; i < 3; i++) begin
      drive_byte(seq[i], obs, exp, clr);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bad_cmd_%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_reset_in_clear();
    logic [15:0] obs, exp;
    logic        clr;
    drive_byte(8'h1B, obs, exp, clr);
    drive_byte(8'h43, obs, exp, clr);
    for (int k = 0; k < 4; k++) begin
      sweep_cycle(k, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rst_clr_sweep_%0d: got %h expected %h", k, obs, exp); end
    end
    reset = 1'b1;
    #1;
    obs = observe();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL rst_clr_async: got %h expected 0000", obs); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pos = 0; m_mode = 0;
    drive_byte(8'h42, obs, exp, clr);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_clr_first: got %h expected %h", obs, exp); end
  endtask

  // random command mix; gaps=0 gives back-to-back strobes
  task automatic test_random(input int n, input logic gaps, input string tag);
    logic [15:0] obs, exp;
    logic        clr;
    logic [7:0]  q [$];
    int          r, inj;
    for (int c = 0; c < n; c++) begin
      q = {};
      r = $urandom_range(0, 99);
      if (r < 60) begin
        q.push_back(8'($urandom));
        if (q[0] == 8'h1B) q[0] = 8'h1C;
      end else if (r < 68) q = {8'h1B, 8'h00};
      else if (r < 73) q = {8'h1B, 8'h53};
      else if (r < 88) begin
        q = {8'h1B, 8'h50};
        q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)));
        q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3)));
      end else if (r < 95) q = {8'h1B, 8'($urandom)};
      else q = {8'h1B, 8'h43};
      foreach (q[i]) begin
        drive_byte(q[i], obs, exp, clr);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s_%0d_%0d: got %h expected %h", tag, c, i, obs, exp); end
        if (clr) begin
          inj = $urandom_range(0, 9);
          for (int k = 0; k < int'(NPOS); k++) begin
            sweep_cycle(k, (k == inj), obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s_%0d_sweep_%0d: got %h expected %h", tag, c, k, obs, exp); end
          end
        end
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            idle_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s_%0d_gap: got %h expected %h", tag, c, obs, exp); end
          end
        end
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_payload_frame();
    test_literal_sync();
    test_goto();
    test_clear_overrun();
    test_bad_cmd();
    test_reset_in_clear();
    test_random(60, 1'b0, "b2b");
    test_random(300, 1'b1, "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
